// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and CDB source indices for the common-data-bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cdb_arbiter_pkg;

  localparam int ROB_POS_WID = 4;
  localparam int DATA_WID    = 32;
  localparam int ADDR_WID    = 32;

  // Producer indices on the CDB
  localparam int CDB_SRC_ALU = 0;
  localparam int CDB_SRC_LSB = 1;
  localparam int CDB_SRC_MDU = 2;
  localparam int CDB_SRC_WID = 2;

  // Round-robin successor of idx among n sources
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-to-arbiter result handshake plus the registered CDB broadcast.
// Latency: n/a (signal bundle only).
// Backpressure: src_ready per source; the broadcast has no ready, consumers always take it.
// Ports: master = producers/consumers side, slave = arbiter side.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int N_SRC     = 3,
  parameter int ROB_POS_W = ROB_POS_WID,
  parameter int DATA_W    = DATA_WID,
  parameter int ADDR_W    = ADDR_WID
);
  logic [N_SRC-1:0]           src_valid;
  logic [N_SRC-1:0]           src_ready;
  logic [N_SRC*ROB_POS_W-1:0] src_rob_pos;
  logic [N_SRC*DATA_W-1:0]    src_val;
  logic [N_SRC-1:0]           src_jump;
  logic [N_SRC*ADDR_W-1:0]    src_pc;

  logic                       cdb_valid;
  logic [CDB_SRC_WID-1:0]     cdb_src;
  logic [ROB_POS_W-1:0]       cdb_rob_pos;
  logic [DATA_W-1:0]          cdb_val;
  logic                       cdb_jump;
  logic [ADDR_W-1:0]          cdb_pc;

  modport master (
    output src_valid, src_rob_pos, src_val, src_jump, src_pc,
    input  src_ready,
    input  cdb_valid, cdb_src, cdb_rob_pos, cdb_val, cdb_jump, cdb_pc
  );

  modport slave (
    input  src_valid, src_rob_pos, src_val, src_jump, src_pc,
    output src_ready,
    output cdb_valid, cdb_src, cdb_rob_pos, cdb_val, cdb_jump, cdb_pc
  );
endinterface

// File: rtl/cdb_src_queue.sv
// Per-producer result FIFO with synchronous clear; head and count are registered-state views.
// Latency: a push is visible at head_o the cycle after it is written.
// Backpressure: pushes beyond DEPTH are dropped; caller gates on count_o != DEPTH.
// Ports: clk, clr_i (sync clear), en_i (freeze when low), push_i/dat_i, pop_i, head_o, count_o.
module cdb_src_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     dat_i,
  output logic [W-1:0]     head_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    do_push = en_i && !clr_i && push_i && (cnt_q != CNT_W'(DEPTH));
    do_pop  = en_i && !clr_i && pop_i && (cnt_q != '0);
    wr_d    = do_push ? bump(wr_q) : wr_q;
    rd_d    = do_pop  ? bump(rd_q) : rd_q;
    cnt_d   = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is not cleared; entries are only observed while counted.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= dat_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter driving one registered CDB broadcast from N_SRC per-source result queues.
// Latency: 1 cycle from an empty-queue push that wins the grant to cdb_valid.
// Backpressure: src_ready = queue not full (registered count only); rdy low freezes everything.
// Ports: clk, rst (sync, active-high), rdy (global enable), flush (rollback), bus (slave side).
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_SRC     = 3,
  parameter int DEPTH     = 2,
  parameter int ROB_POS_W = ROB_POS_WID,
  parameter int DATA_W    = DATA_WID,
  parameter int ADDR_W    = ADDR_WID
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          flush,
  cdb_arbiter_if.slave  bus
);
  localparam int EW    = ROB_POS_W + DATA_W + 1 + ADDR_W;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int RR_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic                   clr;
  logic [EW-1:0]          in_dat   [N_SRC];
  logic [EW-1:0]          head_dat [N_SRC];
  logic [EW-1:0]          cand_dat [N_SRC];
  logic [CNT_W-1:0]       count    [N_SRC];
  logic [N_SRC-1:0]       ready, head_vld, cand_vld, push, pop;

  logic                   gnt_vld;
  logic [RR_W-1:0]        gnt_idx;
  logic [EW-1:0]          gnt_dat;
  logic [RR_W:0]          scan_sum;
  logic [RR_W-1:0]        scan_idx;

  logic [RR_W-1:0]        rr_q, rr_d;
  logic                   cdb_valid_q, cdb_valid_d;
  logic [CDB_SRC_WID-1:0] cdb_src_q, cdb_src_d;
  logic [EW-1:0]          cdb_dat_q, cdb_dat_d;

  assign clr = rst | flush;

  // Candidate per source: queued head first, otherwise the incoming result (bypass).
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      in_dat[i]   = {bus.src_rob_pos[i*ROB_POS_W +: ROB_POS_W], bus.src_val[i*DATA_W +: DATA_W],
                     bus.src_jump[i], bus.src_pc[i*ADDR_W +: ADDR_W]};
      ready[i]    = (count[i] != CNT_W'(DEPTH));
      head_vld[i] = (count[i] != '0);
      cand_vld[i] = head_vld[i] | bus.src_valid[i];
      cand_dat[i] = head_vld[i] ? head_dat[i] : in_dat[i];
    end
  end

  // First candidate at or after rr_q, wrapping modulo N_SRC.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    gnt_dat  = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < N_SRC; k++) begin
      scan_sum = {1'b0, rr_q} + (RR_W+1)'(k);
      if (scan_sum >= (RR_W+1)'(N_SRC)) scan_sum = scan_sum - (RR_W+1)'(N_SRC);
      scan_idx = scan_sum[RR_W-1:0];
      if (!gnt_vld && cand_vld[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx;
        gnt_dat = cand_dat[scan_idx];
      end
    end
  end

  // A bypassed grant never enters its queue; a granted head pops while a same-cycle push still lands.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      pop[i]  = gnt_vld && (gnt_idx == RR_W'(i)) && head_vld[i];
      push[i] = bus.src_valid[i] && ready[i] && !(gnt_vld && (gnt_idx == RR_W'(i)) && !head_vld[i]);
    end
  end

  for (genvar g = 0; g < N_SRC; g++) begin : g_q
    cdb_src_queue #(.DEPTH(DEPTH), .W(EW), .CNT_W(CNT_W)) u_q (
      .clk     (clk),
      .clr_i   (clr),
      .en_i    (rdy),
      .push_i  (push[g]),
      .pop_i   (pop[g]),
      .dat_i   (in_dat[g]),
      .head_o  (head_dat[g]),
      .count_o (count[g])
    );
  end

  always_comb begin
    rr_d        = gnt_vld ? RR_W'(rr_next(int'(gnt_idx), N_SRC)) : rr_q;
    cdb_valid_d = gnt_vld;
    cdb_src_d   = gnt_vld ? CDB_SRC_WID'(gnt_idx) : cdb_src_q;
    cdb_dat_d   = gnt_vld ? gnt_dat : cdb_dat_q;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rr_q        <= '0;
      cdb_valid_q <= 1'b0;
      cdb_src_q   <= '0;
      cdb_dat_q   <= '0;
    end else if (rdy) begin
      rr_q        <= rr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_src_q   <= cdb_src_d;
      cdb_dat_q   <= cdb_dat_d;
    end
  end

  assign bus.src_ready = ready;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_src   = cdb_src_q;
  assign {bus.cdb_rob_pos, bus.cdb_val, bus.cdb_jump, bus.cdb_pc} = cdb_dat_q;
endmodule
